// File: rtl/click_classifier.sv
// Groups debounced click pulses that arrive within a gap window.
// Emits one registered single/double/triple event per closed group.
module click_classifier #(
  parameter int unsigned GAP = 14999999
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       click,
  output logic       single,
  output logic       double,
  output logic       triple,
  output logic       busy,
  output logic [1:0] cnt
);

  localparam int unsigned MAXN = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'b01,
    S_WAIT = 2'b10
  } state_t;

  state_t      r_state;
  logic        r_click_q;
  logic [23:0] r_timer;
  logic [1:0]  r_cnt;
  logic        r_single;
  logic        r_double;
  logic        r_triple;
  logic        r_busy;

  state_t      w_state_nxt;
  logic [23:0] w_timer_nxt;
  logic [1:0]  w_cnt_nxt;
  logic        w_single_nxt;
  logic        w_double_nxt;
  logic        w_triple_nxt;
  logic        w_rise;

  assign w_rise = click & ~r_click_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_click_q <= 1'b0;
      r_timer   <= '0;
      r_cnt     <= '0;
      r_single  <= 1'b0;
      r_double  <= 1'b0;
      r_triple  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_click_q <= click;
      r_timer   <= w_timer_nxt;
      r_cnt     <= w_cnt_nxt;
      r_single  <= w_single_nxt;
      r_double  <= w_double_nxt;
      r_triple  <= w_triple_nxt;
      r_busy    <= (w_state_nxt == S_WAIT);
    end
  end

  // A rise takes priority over timeout, so a click on the timeout edge still counts.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_cnt_nxt    = r_cnt;
    w_single_nxt = 1'b0;
    w_double_nxt = 1'b0;
    w_triple_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        w_cnt_nxt   = '0;
        if (w_rise) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 2'd1;
        end
      end
      S_WAIT: begin
        if (w_rise) begin
          w_timer_nxt = '0;
          if (r_cnt >= 2'(MAXN - 1)) begin
            w_triple_nxt = 1'b1;
            w_cnt_nxt    = '0;
            w_state_nxt  = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end else if (r_timer >= 24'(GAP)) begin
          w_single_nxt = (r_cnt == 2'd1);
          w_double_nxt = (r_cnt != 2'd1);
          w_cnt_nxt    = '0;
          w_timer_nxt  = '0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + 24'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_timer_nxt = '0;
      end
    endcase
  end

  assign single = r_single;
  assign double = r_double;
  assign triple = r_triple;
  assign busy   = r_busy;
  assign cnt    = r_cnt;

endmodule
